// File: rtl/spi_arb_pkg.sv
// Shared types and pad park values for the SPI flash port arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GNT0,
    GNT1,
    GUARD,
    FORCE
  } arb_state_t;

  localparam logic [3:0] PARK_DQ_O  = 4'b0000;
  localparam logic [3:0] PARK_DQ_OE = 4'b0000;
  localparam logic       PARK_CSN   = 1'b1;
  localparam logic       PARK_SCK   = 1'b0;

endpackage

// File: rtl/spi_arb_sync.sv
// Multi-flop synchroniser for a single asynchronous control input; the reset
// value is a port so the same cell serves both req (idle 0) and csn (idle 1).
module spi_arb_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain <= {STAGES{rst_val}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// Two-master arbiter for a single SPI/QSPI flash port. Ownership changes only
// at transaction boundaries, with a parked guard interval between owners and
// a watchdog that reclaims the port from an owner that left csn low.
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int GUARD_CYCLES = 4,
  parameter int CSN_TIMEOUT  = 1024,
  parameter int ROUND_ROBIN  = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req0,
  output logic       gnt0,
  input  logic       csn0,
  input  logic       sck0,
  input  logic [3:0] dq_o0,
  input  logic [3:0] dq_oe0,
  input  logic       req1,
  output logic       gnt1,
  input  logic       csn1,
  input  logic       sck1,
  input  logic [3:0] dq_o1,
  input  logic [3:0] dq_oe1,
  output logic [3:0] dq_i,
  output logic       phy_csn,
  output logic       phy_sck,
  output logic [3:0] phy_dq_o,
  output logic [3:0] phy_dq_oe,
  input  logic [3:0] phy_dq_i,
  output logic       busy,
  output logic       err_timeout
);

  localparam int WD_W = $clog2(CSN_TIMEOUT + 1);
  localparam int GD_W = $clog2(GUARD_CYCLES + 1);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(CSN_TIMEOUT - 1);
  localparam logic [GD_W-1:0] GD_LAST = GD_W'(GUARD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] run_chain;
  logic                   run;
  logic                   req0_s, req1_s, csn0_s, csn1_s;
  logic                   own_req, own_csn;

  arb_state_t             state, state_next;
  logic [WD_W-1:0]        wd_cnt, wd_next;
  logic [GD_W-1:0]        gd_cnt, gd_next;
  logic                   rr, rr_next;
  logic                   err, err_next;

  spi_arb_sync #(.STAGES(SYNC_STAGES)) u_sync_req0 (
    .clk(clk), .rstn(rstn), .rst_val(1'b0), .d(req0), .q(req0_s)
  );
  spi_arb_sync #(.STAGES(SYNC_STAGES)) u_sync_req1 (
    .clk(clk), .rstn(rstn), .rst_val(1'b0), .d(req1), .q(req1_s)
  );
  spi_arb_sync #(.STAGES(SYNC_STAGES)) u_sync_csn0 (
    .clk(clk), .rstn(rstn), .rst_val(1'b1), .d(csn0), .q(csn0_s)
  );
  spi_arb_sync #(.STAGES(SYNC_STAGES)) u_sync_csn1 (
    .clk(clk), .rstn(rstn), .rst_val(1'b1), .d(csn1), .q(csn1_s)
  );

  // Reset release is synchronised: the FSM stays frozen until ones ripple through.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_chain <= '0;
    end else begin
      run_chain <= {run_chain[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign run = run_chain[SYNC_STAGES-1];

  // The current owner's synchronised handshake, used by both grant states.
  assign own_req = (state == GNT1) ? req1_s : req0_s;
  assign own_csn = (state == GNT1) ? csn1_s : csn0_s;

  // State, counters, round-robin preference and sticky error registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      wd_cnt <= '0;
      gd_cnt <= '0;
      rr     <= 1'b0;
      err    <= 1'b0;
    end else if (run) begin
      state  <= state_next;
      wd_cnt <= wd_next;
      gd_cnt <= gd_next;
      rr     <= rr_next;
      err    <= err_next;
    end
  end

  // Next-state logic: arbitration in IDLE, hold/watchdog in GNTn, guard timing.
  always_comb begin
    state_next = state;
    wd_next    = wd_cnt;
    gd_next    = gd_cnt;
    rr_next    = rr;
    err_next   = err;
    case (state)
      IDLE: begin
        wd_next = '0;
        gd_next = '0;
        // rr holds the requester preferred on a tie (only used in round-robin mode).
        if (req0_s && (!req1_s || (ROUND_ROBIN == 0) || !rr)) begin
          state_next = GNT0;
          rr_next    = 1'b1;
        end else if (req1_s) begin
          state_next = GNT1;
          rr_next    = 1'b0;
        end
      end
      GNT0, GNT1: begin
        if (own_req) begin
          wd_next = '0;
        end else if (own_csn) begin
          state_next = GUARD;
          wd_next    = '0;
          gd_next    = '0;
        end else if (wd_cnt == WD_LAST) begin
          state_next = FORCE;
          err_next   = 1'b1;
          wd_next    = '0;
        end else begin
          wd_next = wd_cnt + 1'b1;
        end
      end
      FORCE: begin
        state_next = GUARD;
        gd_next    = '0;
      end
      GUARD: begin
        // Counter only advances below its terminal value, so it cannot wrap.
        if (gd_cnt >= GD_LAST) begin
          state_next = IDLE;
        end else begin
          gd_next = gd_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign gnt0        = (state == GNT0);
  assign gnt1        = (state == GNT1);
  assign busy        = (state != IDLE);
  assign err_timeout = err;
  assign dq_i        = phy_dq_i;

  // Pad mux keyed on the registered grant so the owner's sck reaches the pad unretimed.
  always_comb begin
    phy_csn   = PARK_CSN;
    phy_sck   = PARK_SCK;
    phy_dq_o  = PARK_DQ_O;
    phy_dq_oe = PARK_DQ_OE;
    if (gnt0) begin
      phy_csn   = csn0;
      phy_sck   = sck0;
      phy_dq_o  = dq_o0;
      phy_dq_oe = dq_oe0;
    end else if (gnt1) begin
      phy_csn   = csn1;
      phy_sck   = sck1;
      phy_dq_o  = dq_o1;
      phy_dq_oe = dq_oe1;
    end
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Randomised scoreboard bench for spi_flash_arbiter with a cycle-level
// behavioural reference model of the arbitration rules.
module tb_spi_flash_arbiter;

  localparam int SYNC  = 2;
  localparam int GUARD = 4;
  localparam int TOUT  = 16;
  localparam int RR    = 1;
  localparam int NCYC  = 4000;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req0, csn0, sck0, req1, csn1, sck1;
  logic [3:0] dq_o0, dq_oe0, dq_o1, dq_oe1, phy_dq_i;
  logic       gnt0, gnt1, phy_csn, phy_sck, busy, err_timeout;
  logic [3:0] dq_i, phy_dq_o, phy_dq_oe;

  spi_flash_arbiter #(
    .SYNC_STAGES(SYNC), .GUARD_CYCLES(GUARD), .CSN_TIMEOUT(TOUT), .ROUND_ROBIN(RR)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .gnt0(gnt0), .csn0(csn0), .sck0(sck0), .dq_o0(dq_o0), .dq_oe0(dq_oe0),
    .req1(req1), .gnt1(gnt1), .csn1(csn1), .sck1(sck1), .dq_o1(dq_o1), .dq_oe1(dq_oe1),
    .dq_i(dq_i), .phy_csn(phy_csn), .phy_sck(phy_sck), .phy_dq_o(phy_dq_o),
    .phy_dq_oe(phy_dq_oe), .phy_dq_i(phy_dq_i), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Scoreboard of expected {gnt0,gnt1,busy,err} changes stamped with the cycle.
  typedef struct {
    int         cyc;
    logic [3:0] v;
  } ev_t;
  ev_t sb[$];

  // Reference model: phases as plain integers.
  localparam int P_IDLE = 0, P_OWN = 1, P_FORCE = 2, P_GUARD = 3;
  int   m_phase = P_IDLE;
  int   m_owner = 0;
  int   m_pref  = 0;
  int   m_wd    = 0;
  int   m_guard = 0;
  bit   m_err   = 0;
  logic [3:0] m_last = 4'b0000;
  int   exp_owner = -1;
  int   cyc = 0;
  bit   mon_en = 0;
  bit   h_r0[$], h_r1[$], h_c0[$], h_c1[$];

  // Advance the model by one clock edge using inputs seen SYNC edges earlier.
  task automatic model_step();
    bit r0, r1, c0, c1, rq, cs;
    logic [3:0] v;
    h_r0.push_back(req0); r0 = h_r0.pop_front();
    h_r1.push_back(req1); r1 = h_r1.pop_front();
    h_c0.push_back(csn0); c0 = h_c0.pop_front();
    h_c1.push_back(csn1); c1 = h_c1.pop_front();
    case (m_phase)
      P_IDLE: begin
        if (r0 || r1) begin
          if (r0 && r1) m_owner = (RR != 0) ? m_pref : 0;
          else          m_owner = r0 ? 0 : 1;
          m_pref  = 1 - m_owner;
          m_wd    = 0;
          m_phase = P_OWN;
        end
      end
      P_OWN: begin
        rq = (m_owner == 0) ? r0 : r1;
        cs = (m_owner == 0) ? c0 : c1;
        if (rq) m_wd = 0;
        else if (cs) begin
          m_phase = P_GUARD;
          m_guard = GUARD;
        end else begin
          m_wd++;
          if (m_wd == TOUT) begin
            m_phase = P_FORCE;
            m_err   = 1;
          end
        end
      end
      P_FORCE: begin
        m_phase = P_GUARD;
        m_guard = GUARD;
      end
      default: begin
        m_guard--;
        if (m_guard == 0) m_phase = P_IDLE;
      end
    endcase
    exp_owner = (m_phase == P_OWN) ? m_owner : -1;
    v = {exp_owner == 0, exp_owner == 1, m_phase != P_IDLE, m_err};
    if (v != m_last) begin
      sb.push_back('{cyc: cyc + 1, v: v});
      m_last = v;
    end
  endtask

  // Monitor: compare each observed output change against the scoreboard, and pads every cycle.
  initial begin : monitor
    logic [3:0] last_v, v;
    logic [9:0] exp_pad;
    ev_t e;
    last_v = 4'b0000;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        v = {gnt0, gnt1, busy, err_timeout};
        if (v != last_v) begin
          if (sb.size() == 0) begin
            chk("unexpected_event", {28'd0, v}, {28'd0, last_v});
          end else begin
            e = sb.pop_front();
            chk("event_value", {28'd0, v}, {28'd0, e.v});
            chk("event_cycle", cyc, e.cyc);
          end
          last_v = v;
        end
        if (exp_owner == 0)      exp_pad = {csn0, sck0, dq_o0, dq_oe0};
        else if (exp_owner == 1) exp_pad = {csn1, sck1, dq_o1, dq_oe1};
        else                     exp_pad = {1'b1, 1'b0, 4'h0, 4'h0};
        chk("pads", {22'd0, phy_csn, phy_sck, phy_dq_o, phy_dq_oe}, {22'd0, exp_pad});
        chk("dq_i", {28'd0, dq_i}, {28'd0, phy_dq_i});
        if (gnt0 && gnt1) chk("one_hot", 32'd1, 32'd0);
      end
    end
  end

  // Random requester behaviour: segments of (req, csn) levels with random lengths.
  int seg_left[2];
  bit cur_req[2];
  bit cur_csn[2];

  task automatic drive_random();
    for (int i = 0; i < 2; i++) begin
      if (seg_left[i] == 0) begin
        case ($urandom_range(0, 3))
          0: begin cur_req[i] = 1; cur_csn[i] = 1'($urandom_range(0, 1)); seg_left[i] = $urandom_range(1, 25); end
          1: begin cur_req[i] = 0; cur_csn[i] = 1; seg_left[i] = $urandom_range(1, 20); end
          2: begin cur_req[i] = 0; cur_csn[i] = 0; seg_left[i] = $urandom_range(1, 30); end
          default: begin cur_req[i] = 1; cur_csn[i] = 0; seg_left[i] = $urandom_range(5, 25); end
        endcase
      end
      seg_left[i]--;
    end
    req0 = cur_req[0]; csn0 = cur_csn[0];
    req1 = cur_req[1]; csn1 = cur_csn[1];
    sck0 = 1'($urandom_range(0, 1)); sck1 = 1'($urandom_range(0, 1));
    dq_o0 = 4'($urandom); dq_oe0 = 4'($urandom);
    dq_o1 = 4'($urandom); dq_oe1 = 4'($urandom);
    phy_dq_i = 4'($urandom);
  endtask

  // One clock of model evaluation followed by input update at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  initial begin : driver
    int budget;
    rstn = 1'b0;
    req0 = 0; req1 = 0; csn0 = 0; csn1 = 1; sck0 = 1; sck1 = 1;
    dq_o0 = 4'hF; dq_oe0 = 4'hF; dq_o1 = 4'hA; dq_oe1 = 4'hF; phy_dq_i = 4'h5;
    for (int i = 0; i < SYNC; i++) begin
      h_r0.push_back(0); h_r1.push_back(0); h_c0.push_back(1); h_c1.push_back(1);
    end
    seg_left[0] = 0; seg_left[1] = 0;
    #1;
    chk("rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    chk("rst_busy_err", {30'd0, busy, err_timeout}, 32'd0);
    chk("rst_pads", {22'd0, phy_csn, phy_sck, phy_dq_o, phy_dq_oe}, {22'd0, 10'b10_0000_0000});
    repeat (3) @(negedge clk);
    csn0 = 1;
    rstn = 1'b1;
    mon_en = 1;
    repeat (10) tick();
    for (int n = 0; n < NCYC; n++) begin
      drive_random();
      tick();
    end
    // Bring requester 0 into ownership with csn0 low, then reset asynchronously.
    req0 = 1; csn0 = 0; req1 = 0; csn1 = 1;
    sck0 = 1; dq_o0 = 4'hF; dq_oe0 = 4'hF;
    budget = 0;
    while (exp_owner != 0 && budget < 200) begin
      tick();
      budget++;
    end
    chk("final_grant_reached", {31'd0, exp_owner == 0}, 32'd1);
    repeat (3) tick();
    chk("gnt0_before_reset", {31'd0, gnt0}, 32'd1);
    mon_en = 0;
    chk("scoreboard_drained", sb.size(), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    chk("arst_busy_err", {30'd0, busy, err_timeout}, 32'd0);
    chk("arst_pads", {22'd0, phy_csn, phy_sck, phy_dq_o, phy_dq_oe}, {22'd0, 10'b10_0000_0000});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
